// File: rtl/gol_pkg.sv
// Shared Game-of-Life constants and the display-scan state encoding.
package gol_pkg;
  localparam int GRID_ROWS = 16;
  localparam int GRID_COLS = 16;
  localparam int GRID_W    = GRID_ROWS * GRID_COLS;

  typedef enum logic [1:0] {SCAN_IDLE, SCAN_LOAD, SCAN_SHOW, SCAN_BLANK} scan_state_e;
endpackage

// File: rtl/grid_scan.sv
// Row-multiplexed LED matrix scanner; snapshots the generation grid once per frame.
module grid_scan
  import gol_pkg::*;
#(
  parameter int ROWS  = GRID_ROWS,
  parameter int COLS  = GRID_COLS,
  parameter int DWELL = 1000,
  parameter int BLANK = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ROWS*COLS-1:0]    grid_in,
  input  logic                    enable,
  output logic [ROWS-1:0]         row_sel,
  output logic [COLS-1:0]         col_data,
  output logic [$clog2(ROWS)-1:0] row_idx,
  output logic                    frame_done,
  output logic                    busy
);
  localparam int RW   = $clog2(ROWS);
  localparam int CMAX = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CW   = $clog2(CMAX + 1);

  scan_state_e          state, nxt;
  logic [CW-1:0]        cnt;
  logic [RW-1:0]        row;
  logic [ROWS*COLS-1:0] shadow;
  logic                 show_end, blank_end, row_end, last_row;

  assign show_end  = (state == SCAN_SHOW) && (cnt == CW'(DWELL - 1));
  assign blank_end = (BLANK > 0) && (state == SCAN_BLANK) && (cnt == CW'(BLANK - 1));
  // With no blank gap the row finishes on its last lit cycle.
  assign row_end   = (BLANK == 0) ? show_end : blank_end;
  assign last_row  = (row == RW'(ROWS - 1));

  always_comb begin
    nxt = state;
    unique case (state)
      SCAN_IDLE:  if (enable) nxt = SCAN_LOAD;
      SCAN_LOAD:  nxt = SCAN_SHOW;
      SCAN_SHOW:  if (show_end) begin
                    if (BLANK > 0)     nxt = SCAN_BLANK;
                    else if (!last_row) nxt = SCAN_SHOW;
                    else               nxt = enable ? SCAN_LOAD : SCAN_IDLE;
                  end
      SCAN_BLANK: if (blank_end) begin
                    if (!last_row) nxt = SCAN_SHOW;
                    else           nxt = enable ? SCAN_LOAD : SCAN_IDLE;
                  end
      default:    nxt = SCAN_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= SCAN_IDLE;
      cnt    <= '0;
      row    <= '0;
      shadow <= '0;
    end else begin
      state <= nxt;
      if ((state == SCAN_SHOW || state == SCAN_BLANK) && !show_end && !blank_end)
        cnt <= cnt + CW'(1);
      else
        cnt <= '0;
      // Grid is captured only here so a frame never mixes two generations.
      if (state == SCAN_LOAD) begin
        shadow <= grid_in;
        row    <= '0;
      end else if (row_end) begin
        row <= last_row ? '0 : row + RW'(1);
      end
    end
  end

  assign row_sel    = (state == SCAN_SHOW) ? (ROWS'(1) << row) : '0;
  assign col_data   = (state == SCAN_SHOW) ? shadow[COLS*row +: COLS] : '0;
  assign row_idx    = row;
  assign frame_done = row_end && last_row;
  assign busy       = (state != SCAN_IDLE);
endmodule
